rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter MAX_FETCH_RUN, default 8, meaning the maximum consecutive fetch grants while a dump read waits (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port fetch_req  input  1  CPU instruction read request, level, sampled each cycle.
REQ-005 SHALL have port fetch_addr  input  15  CPU instruction address.
REQ-006 SHALL have port fetch_grant  output  1  combinational, fetch read issued this cycle.
REQ-007 SHALL have port fetch_valid  output  1  registered, fetch_data valid this cycle.
REQ-008 SHALL have port fetch_data  output  16  registered instruction word.
REQ-009 SHALL have port dump_start  input  1  single-cycle pulse starting a sequential dump.
REQ-010 SHALL have port dump_base  input  15  first dump address, captured on dump_start.
REQ-011 SHALL have port dump_len  input  16  word count, captured on dump_start.
REQ-012 SHALL have port dump_valid  output  1  dump word presented.
REQ-013 SHALL have port dump_ready  input  1  consumer accepts dump word.
REQ-014 SHALL have port dump_data  output  16  dump word.
REQ-015 SHALL have port dump_busy  output  1  dump in progress.
REQ-016 SHALL have port dump_done  output  1  one-cycle pulse, dump complete.
REQ-017 SHALL have port rom_address  output  15  address to asynchronous ROM, combinational from grant.
REQ-018 SHALL have port rom_data  input  16  asynchronous ROM read data.

Function
REQ-019 SHALL implement dump FSM states D_IDLE, D_READ (awaiting ROM slot), D_HOLD (word presented, awaiting ready).
REQ-020 SHALL in D_IDLE on dump_start capture base into dump pointer and len into remaining counter; len>0 -> D_READ, len=0 -> stay D_IDLE and pulse dump_done next cycle.
REQ-021 SHALL ignore dump_start when not in D_IDLE.
REQ-022 SHALL grant one ROM read per cycle: fetch wins when fetch_req=1, except dump wins when in D_READ and starvation counter equals MAX_FETCH_RUN, or fetch_req=0.
REQ-023 SHALL increment starvation counter on each fetch grant while in D_READ, clear it on dump grant and in D_IDLE, saturating at MAX_FETCH_RUN.
REQ-024 SHALL drive rom_address = fetch_addr on fetch grant, dump pointer on dump grant, 0 when idle.
REQ-025 SHALL on fetch grant in cycle N assert fetch_valid with fetch_data = ROM[fetch_addr] in cycle N+1; no grant -> fetch_valid=0 at N+1, fetch_data holds previous value; requester keeps fetch_req asserted.
REQ-026 SHALL on dump grant in cycle N register rom_data into dump_data, assert dump_valid from N+1, enter D_HOLD, increment pointer, decrement remaining.
REQ-027 SHALL hold dump_data and dump_valid stable in D_HOLD until dump_valid&&dump_ready; no dump read issued while in D_HOLD.
REQ-028 SHALL on acceptance go to D_READ if remaining>0, else D_IDLE with dump_done=1 that cycle+1 for exactly one cycle.
REQ-029 SHALL wrap dump pointer 32767 -> 0 without error.
REQ-030 SHALL assert dump_busy in D_READ and D_HOLD only.
REQ-031 SHALL allow fetch grants every cycle while dump is in D_HOLD or D_IDLE.

Reset
REQ-032 SHALL on reset asynchronously force D_IDLE, counters 0, pointer 0, and fetch_valid, fetch_data, dump_valid, dump_data, dump_busy, dump_done to 0.
REQ-033 SHALL abandon any in-flight dump on reset without dump_done pulse.

Verification
REQ-034 Fetch only: ROM[5]=16'h1234, fetch_req=1 addr=5 cycle N -> fetch_grant=1 at N, fetch_valid=1 data=16'h1234 at N+1.
REQ-035 Dump with idle fetch: base=10, len=3, dump_ready=1 -> words ROM[10..12] on consecutive accepts, dump_done one cycle after third accept, dump_busy low afterwards.
REQ-036 Starvation: MAX_FETCH_RUN=8, fetch_req held 1, dump len=2 -> exactly one dump grant after every 8 fetch grants, fetch_valid=0 in the cycle after each dump grant.
REQ-037 Backpressure and wrap: base=32766, len=3, dump_ready low 5 cycles per word -> dump_data stable while held, addresses 32766, 32767, 0 in order.
REQ-038 Edge cases: dump_len=0 -> dump_done pulse, no dump_valid; dump_start during busy ignored; reset asserted in D_HOLD -> all outputs 0 immediately, no dump_done.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: arbitrates one async ROM between CPU fetches and a sequential dump reader
module rom_arbiter #(
    parameter int MAX_FETCH_RUN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [14:0] fetch_addr,
    output logic        fetch_grant,
    output logic        fetch_valid,
    output logic [15:0] fetch_data,
    input  logic        dump_start,
    input  logic [14:0] dump_base,
    input  logic [15:0] dump_len,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [15:0] dump_data,
    output logic        dump_busy,
    output logic        dump_done,
    output logic [14:0] rom_address,
    input  logic [15:0] rom_data
);
    typedef enum logic [1:0] {D_IDLE, D_READ, D_HOLD} dstate_t;

    localparam logic [7:0] MAX_RUN = 8'(MAX_FETCH_RUN);

    dstate_t     state, state_nx;
    logic [14:0] ptr;
    logic [15:0] remaining;
    logic [7:0]  starve;
    logic        dump_grant;
    logic        accept;

    // fetch has priority unless a waiting dump has been starved long enough
    always_comb begin
        dump_grant  = (state == D_READ) && (!fetch_req || starve == MAX_RUN);
        fetch_grant = fetch_req && !dump_grant;
        rom_address = fetch_grant ? fetch_addr : dump_grant ? ptr : 15'd0;
        accept      = (state == D_HOLD) && dump_ready;
        dump_busy   = state != D_IDLE;
    end

    // dump FSM next-state
    always_comb begin
        state_nx = state;
        case (state)
            D_IDLE:  if (dump_start && dump_len != 16'd0) state_nx = D_READ;
            D_READ:  if (dump_grant) state_nx = D_HOLD;
            D_HOLD:  if (dump_ready) state_nx = (remaining != 16'd0) ? D_READ : D_IDLE;
            default: state_nx = D_IDLE;
        endcase
    end

    // dump FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= D_IDLE;
        else       state <= state_nx;
    end

    // read-data capture, dump bookkeeping and starvation counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            remaining   <= '0;
            starve      <= '0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_done   <= 1'b0;
        end else begin
            fetch_valid <= fetch_grant;
            if (fetch_grant) fetch_data <= rom_data;
            dump_done <= (state == D_IDLE && dump_start && dump_len == 16'd0) ||
                         (accept && remaining == 16'd0);
            if (state == D_IDLE && dump_start) begin
                ptr       <= dump_base;
                remaining <= dump_len;
            end
            if (dump_grant) begin
                dump_data  <= rom_data;
                dump_valid <= 1'b1;
                ptr        <= ptr + 15'd1;
                remaining  <= remaining - 16'd1;
            end else if (accept) begin
                dump_valid <= 1'b0;
            end
            starve <= (state != D_READ || dump_grant) ? 8'd0 :
                      (fetch_grant && starve != MAX_RUN) ? starve + 8'd1 : starve;
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vector table plus starvation, backpressure/wrap and reset sequences
module tb_rom_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [14:0] fetch_addr;
    logic        fetch_grant;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        dump_start;
    logic [14:0] dump_base;
    logic [15:0] dump_len;
    logic        dump_valid;
    logic        dump_ready;
    logic [15:0] dump_data;
    logic        dump_busy;
    logic        dump_done;
    logic [14:0] rom_address;
    logic [15:0] rom_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        fr;
        logic [14:0] fa;
        logic        ds;
        logic [14:0] db;
        logic [15:0] dl;
        logic        rdy;
        logic        g;
        logic [14:0] ra;
        logic        fv;
        logic [15:0] fd;
        logic        dv;
        logic [15:0] dd;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[16];

    rom_arbiter #(.MAX_FETCH_RUN(8)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done),
        .rom_address(rom_address), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [14:0] a);
        return (a == 15'd5) ? 16'h1234 : {1'b1, a};
    endfunction

    assign rom_data = rom_f(rom_address);

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic edge_in();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] a;
        reset = 1'b1; fetch_req = 0; fetch_addr = 0; dump_start = 0;
        dump_base = 0; dump_len = 0; dump_ready = 0;
        tbl[0]  = '{0, 0,  0, 0,   0, 0,  0, 0,  0, 16'h0000, 0, 16'h0000, 0, 0};
        tbl[1]  = '{1, 5,  0, 0,   0, 0,  1, 5,  0, 16'h0000, 0, 16'h0000, 0, 0};
        tbl[2]  = '{0, 0,  0, 0,   0, 0,  0, 0,  1, 16'h1234, 0, 16'h0000, 0, 0};
        tbl[3]  = '{1, 7,  0, 0,   0, 0,  1, 7,  0, 16'h1234, 0, 16'h0000, 0, 0};
        tbl[4]  = '{0, 0,  0, 0,   0, 1,  0, 0,  1, 16'h8007, 0, 16'h0000, 0, 0};
        tbl[5]  = '{0, 0,  1, 10,  3, 1,  0, 0,  0, 16'h8007, 0, 16'h0000, 0, 0};
        tbl[6]  = '{0, 0,  0, 0,   0, 1,  0, 10, 0, 16'h8007, 0, 16'h0000, 1, 0};
        tbl[7]  = '{0, 0,  0, 0,   0, 1,  0, 0,  0, 16'h8007, 1, 16'h800A, 1, 0};
        tbl[8]  = '{0, 0,  1, 100, 9, 1,  0, 11, 0, 16'h8007, 0, 16'h800A, 1, 0};
        tbl[9]  = '{1, 5,  0, 0,   0, 1,  1, 5,  0, 16'h8007, 1, 16'h800B, 1, 0};
        tbl[10] = '{0, 0,  0, 0,   0, 1,  0, 12, 1, 16'h1234, 0, 16'h800B, 1, 0};
        tbl[11] = '{0, 0,  0, 0,   0, 1,  0, 0,  0, 16'h1234, 1, 16'h800C, 1, 0};
        tbl[12] = '{0, 0,  0, 0,   0, 1,  0, 0,  0, 16'h1234, 0, 16'h800C, 0, 1};
        tbl[13] = '{0, 0,  1, 3,   0, 1,  0, 0,  0, 16'h1234, 0, 16'h800C, 0, 0};
        tbl[14] = '{0, 0,  0, 0,   0, 1,  0, 0,  0, 16'h1234, 0, 16'h800C, 0, 1};
        tbl[15] = '{0, 0,  0, 0,   0, 1,  0, 0,  0, 16'h1234, 0, 16'h800C, 0, 0};

        repeat (2) edge_in();
        chk("reset fetch_valid", 32'(fetch_valid), 0);
        chk("reset dump_busy", 32'(dump_busy), 0);
        chk("reset dump_done", 32'(dump_done), 0);
        chk("reset rom_address", 32'(rom_address), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            edge_in();
            fetch_req = tbl[i].fr; fetch_addr = tbl[i].fa; dump_start = tbl[i].ds;
            dump_base = tbl[i].db; dump_len = tbl[i].dl; dump_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("row%0d fetch_grant", i), 32'(fetch_grant), 32'(tbl[i].g));
            chk($sformatf("row%0d rom_address", i), 32'(rom_address), 32'(tbl[i].ra));
            chk($sformatf("row%0d fetch_valid", i), 32'(fetch_valid), 32'(tbl[i].fv));
            chk($sformatf("row%0d fetch_data", i), 32'(fetch_data), 32'(tbl[i].fd));
            chk($sformatf("row%0d dump_valid", i), 32'(dump_valid), 32'(tbl[i].dv));
            chk($sformatf("row%0d dump_data", i), 32'(dump_data), 32'(tbl[i].dd));
            chk($sformatf("row%0d dump_busy", i), 32'(dump_busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d dump_done", i), 32'(dump_done), 32'(tbl[i].done));
        end

        // starvation: fetch held high, dump of two words from 40
        edge_in();
        fetch_req = 1; fetch_addr = 20; dump_start = 1; dump_base = 40; dump_len = 2; dump_ready = 1;
        @(negedge clk);
        chk("starve start grant", 32'(fetch_grant), 1);
        edge_in();
        dump_start = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk($sformatf("starve w%0d fetch%0d grant", k, i), 32'(fetch_grant), 1);
                chk($sformatf("starve w%0d fetch%0d busy", k, i), 32'(dump_busy), 1);
                edge_in();
            end
            @(negedge clk);
            chk($sformatf("starve w%0d dump grant", k), 32'(fetch_grant), 0);
            chk($sformatf("starve w%0d dump addr", k), 32'(rom_address), 32'(40 + k));
            edge_in();
            @(negedge clk);
            chk($sformatf("starve w%0d fetch_valid gap", k), 32'(fetch_valid), 0);
            chk($sformatf("starve w%0d dump_valid", k), 32'(dump_valid), 1);
            chk($sformatf("starve w%0d dump_data", k), 32'(dump_data), 32'(rom_f(15'(40 + k))));
            chk($sformatf("starve w%0d hold fetch grant", k), 32'(fetch_grant), 1);
            edge_in();
        end
        @(negedge clk);
        chk("starve done", 32'(dump_done), 1);
        chk("starve busy after", 32'(dump_busy), 0);
        chk("starve fetch_valid after hold", 32'(fetch_valid), 1);

        // backpressure and pointer wrap
        edge_in();
        fetch_req = 0; dump_ready = 0; dump_start = 1; dump_base = 15'd32766; dump_len = 3;
        edge_in();
        dump_start = 0;
        for (int k = 0; k < 3; k++) begin
            a = 15'd32766 + 15'(k);
            @(negedge clk);
            chk($sformatf("wrap w%0d addr", k), 32'(rom_address), 32'(a));
            chk($sformatf("wrap w%0d busy", k), 32'(dump_busy), 1);
            edge_in();
            for (int h = 0; h < 5; h++) begin
                @(negedge clk);
                chk($sformatf("wrap w%0d hold%0d valid", k, h), 32'(dump_valid), 1);
                chk($sformatf("wrap w%0d hold%0d data", k, h), 32'(dump_data), 32'(rom_f(a)));
                chk($sformatf("wrap w%0d hold%0d no read", k, h), 32'(rom_address), 0);
                edge_in();
            end
            dump_ready = 1;
            @(negedge clk);
            chk($sformatf("wrap w%0d accept data", k), 32'(dump_data), 32'(rom_f(a)));
            chk($sformatf("wrap w%0d accept done", k), 32'(dump_done), 0);
            edge_in();
            dump_ready = 0;
        end
        @(negedge clk);
        chk("wrap done", 32'(dump_done), 1);
        chk("wrap busy after", 32'(dump_busy), 0);
        chk("wrap dump_valid after", 32'(dump_valid), 0);

        // reset while a word is held
        edge_in();
        fetch_req = 1; fetch_addr = 5; dump_start = 1; dump_base = 50; dump_len = 2; dump_ready = 0;
        edge_in();
        fetch_req = 0; dump_start = 0;
        edge_in();
        @(negedge clk);
        chk("pre-reset dump_valid", 32'(dump_valid), 1);
        chk("pre-reset fetch_data", 32'(fetch_data), 32'h1234);
        reset = 1;
        #1;
        chk("async reset dump_valid", 32'(dump_valid), 0);
        chk("async reset dump_data", 32'(dump_data), 0);
        chk("async reset dump_busy", 32'(dump_busy), 0);
        chk("async reset dump_done", 32'(dump_done), 0);
        chk("async reset fetch_valid", 32'(fetch_valid), 0);
        chk("async reset fetch_data", 32'(fetch_data), 0);
        edge_in();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset%0d done", i), 32'(dump_done), 0);
            chk($sformatf("post-reset%0d busy", i), 32'(dump_busy), 0);
            edge_in();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
